// File: rtl/addsub_pkg.sv
// Shared definitions for the adder_sub result capture path.
// Holds the datapath width, opcode encodings, the buffered result
// payload and the signed-overflow helper used by RTL and scoreboards.
package addsub_pkg;

  localparam int unsigned ADDSUB_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One buffered result with its derived status flags.
  typedef struct packed {
    logic [ADDSUB_W-1:0] sum;
    logic                carry;
    logic                borrow;
    logic                zero;
    logic                ovf;
    logic                sub;
  } result_t;

  // Two's-complement overflow: operands of equal effective sign yielding
  // a result of the opposite sign. B is inverted by the adder on subtract.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                    input logic control, input logic sum_msb);
    logic b_eff;
    b_eff = b_msb ^ control;
    return (a_msb == b_eff) & (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_result_stage_flag_calc.sv
// Purely combinational status flag derivation for one adder_sub result.
// Ports:
//   sum, carry       : adder_sub out / carry_out
//   a_msb, b_msb     : operand sign bits (b raw, before inversion)
//   control          : 0 = add, 1 = subtract
//   borrow_c, zero_c, ovf_c : derived flags
module addsub_result_stage_flag_calc
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_W
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             control,
  output logic             borrow_c,
  output logic             zero_c,
  output logic             ovf_c
);

  // On subtract the adder computes a + ~b + 1, so no carry means a borrow.
  assign borrow_c = (control == OP_SUB) & ~carry;
  assign zero_c   = ~|sum;
  assign ovf_c    = calc_ovf(a_msb, b_msb, control, sum[WIDTH-1]);

endmodule

// File: rtl/addsub_result_stage.sv
// Registered capture stage behind the adder_sub datapath.
// Accepts results under valid/ready, stores them with derived flags in a
// small FIFO and keeps a saturating count of signed-overflow results.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : upstream handshake (ready = not full)
//   in_sum, in_carry         : adder_sub result
//   in_a_msb, in_b_msb       : operand sign bits
//   in_control               : 0 = add, 1 = subtract
//   out_valid / out_ready    : downstream handshake on the head entry
//   out_result .. out_sub    : head entry fields (zero while empty)
//   ovf_count                : saturating overflow event counter
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_W,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic             in_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_sub,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill;
  result_t           mem [DEPTH];

  logic    push;
  logic    pop;
  logic    borrow_c;
  logic    zero_c;
  logic    ovf_c;
  result_t entry;
  result_t head;

  addsub_result_stage_flag_calc #(
    .WIDTH (WIDTH)
  ) u_flag_calc (
    .sum      (in_sum),
    .carry    (in_carry),
    .a_msb    (in_a_msb),
    .b_msb    (in_b_msb),
    .control  (in_control),
    .borrow_c (borrow_c),
    .zero_c   (zero_c),
    .ovf_c    (ovf_c)
  );

  // Ready comes only from registered occupancy, so a full buffer refuses a
  // push even when the consumer pops in the same cycle.
  assign in_ready  = ~rst & (fill < FILL_W'(DEPTH));
  assign out_valid = (fill != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    entry        = '0;
    entry.sum    = ADDSUB_W'(in_sum);
    entry.carry  = in_carry;
    entry.borrow = borrow_c;
    entry.zero   = zero_c;
    entry.ovf    = ovf_c;
    entry.sub    = in_control;
  end

  // Occupancy and pointers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage is written only on an accepted push, so ignored inputs never land.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Saturating overflow event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (push && entry.ovf && !(&ovf_count)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  // Head entry is masked to zero while empty so stale storage never shows.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_result = WIDTH'(head.sum);
  assign out_carry  = head.carry;
  assign out_borrow = head.borrow;
  assign out_zero   = head.zero;
  assign out_ovf    = head.ovf;
  assign out_sub    = head.sub;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed self-checking bench for addsub_result_stage.
module tb_addsub_result_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sum;
  logic       in_carry;
  logic       in_a_msb;
  logic       in_b_msb;
  logic       in_control;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_borrow;
  logic       out_zero;
  logic       out_ovf;
  logic       out_sub;
  logic [7:0] ovf_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  addsub_result_stage #(
    .WIDTH (4),
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_a_msb   (in_a_msb),
    .in_b_msb   (in_b_msb),
    .in_control (in_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_sub    (out_sub),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total checks %0d", total_cnt);
    $fatal(1, "watchdog expired");
  end

  // {out_valid, out_result, out_carry, out_borrow, out_zero, out_ovf, out_sub}
  function automatic logic [9:0] head_obs();
    return {out_valid, out_result, out_carry, out_borrow, out_zero, out_ovf, out_sub};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sum[3:0], carry, a_msb, b_msb, control}
  task automatic drive(input logic [7:0] v);
    {in_sum, in_carry, in_a_msb, in_b_msb, in_control} = v;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sum = '0; in_carry = 0; in_a_msb = 0; in_b_msb = 0; in_control = 0;
    step(); step();
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (head_obs() !== 10'b0) $display("FAIL reset_head got %b want %b", head_obs(), 10'b0);
    else pass_cnt++;
    total_cnt++;
    if (ovf_count !== 8'd0) $display("FAIL reset_ovf_count got %0d want 0", ovf_count);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_flag_vectors();
    logic [7:0] vin [7];
    logic [9:0] vexp [7];
    int         exp_cnt;
    vin[0] = 8'b1010_0_0_0_0; vexp[0] = 10'b1_1010_0_0_0_1_0; // 0111+0011 overflow
    vin[1] = 8'b0100_1_0_0_1; vexp[1] = 10'b1_0100_1_0_0_0_1; // 0111-0011
    vin[2] = 8'b0000_1_0_0_1; vexp[2] = 10'b1_0000_1_0_1_0_1; // 0011-0011
    vin[3] = 8'b1111_0_0_0_1; vexp[3] = 10'b1_1111_0_1_0_0_1; // 0010-0011 borrow
    vin[4] = 8'b0111_1_1_0_1; vexp[4] = 10'b1_0111_1_0_0_1_1; // 1000-0001 overflow
    vin[5] = 8'b0000_1_1_0_0; vexp[5] = 10'b1_0000_1_0_1_0_0; // 1111+0001 wraps to zero
    vin[6] = 8'b0000_1_1_1_0; vexp[6] = 10'b1_0000_1_0_1_1_0; // 1000+1000 overflow
    exp_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vin[i]);
      step();
      in_valid = 1'b0;
      exp_cnt += int'(vexp[i][1]);
      total_cnt++;
      if (head_obs() !== vexp[i])
        $display("FAIL vector%0d_head got %b want %b", i, head_obs(), vexp[i]);
      else pass_cnt++;
      total_cnt++;
      if (ovf_count !== 8'(exp_cnt))
        $display("FAIL vector%0d_ovf_count got %0d want %0d", i, ovf_count, exp_cnt);
      else pass_cnt++;
      step();
      total_cnt++;
      if (head_obs() !== 10'b0)
        $display("FAIL vector%0d_drained got %b want %b", i, head_obs(), 10'b0);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(8'b0001_0_0_0_0);
    step();
    total_cnt++;
    if ({in_ready, head_obs()} !== {1'b1, 10'b1_0001_0_0_0_0_0})
      $display("FAIL bp_after_first got %b want %b", {in_ready, head_obs()}, {1'b1, 10'b1_0001_0_0_0_0_0});
    else pass_cnt++;
    drive(8'b0010_0_0_0_0);
    step();
    total_cnt++;
    if ({in_ready, head_obs()} !== {1'b0, 10'b1_0001_0_0_0_0_0})
      $display("FAIL bp_full got %b want %b", {in_ready, head_obs()}, {1'b0, 10'b1_0001_0_0_0_0_0});
    else pass_cnt++;
    drive(8'b0011_0_0_0_0);
    step();
    total_cnt++;
    if ({in_ready, head_obs()} !== {1'b0, 10'b1_0001_0_0_0_0_0})
      $display("FAIL bp_held got %b want %b", {in_ready, head_obs()}, {1'b0, 10'b1_0001_0_0_0_0_0});
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if ({in_ready, head_obs()} !== {1'b1, 10'b1_0010_0_0_0_0_0})
      $display("FAIL bp_first_pop got %b want %b", {in_ready, head_obs()}, {1'b1, 10'b1_0010_0_0_0_0_0});
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (head_obs() !== 10'b1_0011_0_0_0_0_0)
      $display("FAIL bp_third_accepted got %b want %b", head_obs(), 10'b1_0011_0_0_0_0_0);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({in_ready, head_obs()} !== {1'b1, 10'b0})
      $display("FAIL bp_drained got %b want %b", {in_ready, head_obs()}, {1'b1, 10'b0});
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(8'b1010_0_0_0_0);
    for (int i = 0; i < 260; i++) begin
      step();
      if (i == 253) begin
        total_cnt++;
        if (ovf_count !== 8'd254) $display("FAIL sat_254 got %0d want 254", ovf_count);
        else pass_cnt++;
      end
      if (i == 254) begin
        total_cnt++;
        if (ovf_count !== 8'd255) $display("FAIL sat_255 got %0d want 255", ovf_count);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (ovf_count !== 8'd255) $display("FAIL sat_hold got %0d want 255", ovf_count);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_stream();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(8'b1010_0_0_0_0);
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    step();
    total_cnt++;
    if ({in_ready, out_valid, ovf_count} !== {1'b0, 1'b1, 8'd5})
      $display("FAIL mid_full got %b want %b", {in_ready, out_valid, ovf_count}, {1'b0, 1'b1, 8'd5});
    else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++;
    if ({in_ready, head_obs(), ovf_count} !== {1'b0, 10'b0, 8'd0})
      $display("FAIL mid_reset got %b want %b", {in_ready, head_obs(), ovf_count}, {1'b0, 10'b0, 8'd0});
    else pass_cnt++;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL mid_ready_after got %b want 1", in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({in_ready, out_valid, ovf_count} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL mid_idle got %b want %b", {in_ready, out_valid, ovf_count}, {1'b1, 1'b0, 8'd0});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_flag_vectors();
    test_backpressure();
    test_saturation();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
